// File: rtl/io_periph.sv
// Memory-mapped IO responder for the MMU IO bus: FIFO-buffered 8N1 UART transmitter,
// a 32-bit GPIO output register and a two-flop-synchronised GPIO input.
module io_periph #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          GPIO_IN_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [7:0]           io_addr,
    input  logic                 io_en,
    input  logic                 io_we,
    input  logic [31:0]          io_data_write,
    output logic [31:0]          io_data_read,
    output logic                 uart_tx,
    output logic [31:0]          gpio_out,
    input  logic [GPIO_IN_W-1:0] gpio_in,
    output logic                 tx_idle
);

    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    localparam logic [5:0] A_TXDATA = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_BAUD   = 6'd2;
    localparam logic [5:0] A_GPO    = 6'd3;
    localparam logic [5:0] A_GPI    = 6'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    // Bus decode
    logic [5:0] word;
    logic       wr_en;
    logic       push_req;
    logic       ovf_clr;
    logic       unused_addr_lsbs;

    assign word             = io_addr[7:2];
    assign wr_en            = io_en && io_we;
    assign push_req         = wr_en && (word == A_TXDATA);
    assign ovf_clr          = wr_en && (word == A_STATUS) && io_data_write[3];
    assign unused_addr_lsbs = ^io_addr[1:0];

    // Registers
    logic [15:0]          div_q;
    logic [31:0]          gpio_out_q;
    logic [GPIO_IN_W-1:0] sync1_q;
    logic [GPIO_IN_W-1:0] sync2_q;
    logic                 ovf_q;
    logic                 ovf_d;

    // TX FIFO
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;

    // Transmitter
    tx_state_e   state_q;
    logic [15:0] baud_cnt_q;
    logic [15:0] period_m1;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        bit_done;
    logic        busy;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign busy      = (state_q != S_IDLE);
    assign bit_done  = (baud_cnt_q == 16'd0);
    // A divisor of 0 behaves as 1 cycle per bit.
    assign period_m1 = (div_q == 16'd0) ? 16'd0 : (div_q - 16'd1);
    assign pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
    // A push into a full FIFO still fits when the transmitter pops on the same edge.
    assign push_ok   = push_req && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= io_data_write[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            div_q      <= DEFAULT_DIV;
            gpio_out_q <= 32'd0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            if (wr_en && (word == A_BAUD)) begin
                div_q <= io_data_write[15:0];
            end
            if (wr_en && (word == A_GPO)) begin
                gpio_out_q <= io_data_write;
            end
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    // The bit counter reloads from div_q only at bit boundaries, so divisor writes never stretch a bit.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_q    <= S_START;
                        tx_q       <= 1'b0;
                        shift_q    <= fifo_q[rd_ptr_q];
                        baud_cnt_q <= period_m1;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state_q    <= S_DATA;
                        tx_q       <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_idx_q  <= 3'd0;
                        baud_cnt_q <= period_m1;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        baud_cnt_q <= period_m1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (!empty) begin
                            state_q    <= S_START;
                            tx_q       <= 1'b0;
                            shift_q    <= fifo_q[rd_ptr_q];
                            baud_cnt_q <= period_m1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        io_data_read = 32'd0;
        if (io_en) begin
            case (word)
                A_STATUS: io_data_read = {28'd0, ovf_q, empty, full, busy};
                A_BAUD:   io_data_read = {16'd0, div_q};
                A_GPO:    io_data_read = gpio_out_q;
                A_GPI:    io_data_read[GPIO_IN_W-1:0] = sync2_q;
                default:  io_data_read = 32'd0;
            endcase
        end
    end

    assign uart_tx  = tx_q;
    assign gpio_out = gpio_out_q;
    assign tx_idle  = !busy && empty;

endmodule
